// File: rtl/fpu_faddsub_pipe_if.sv
// Issue/writeback handshake bundle for the pipelined IEEE-754 add/subtract unit.
// Issue side drives operands and tag; writeback side consumes result, overflow flag and tag.
interface fpu_faddsub_pipe_if #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EW + MW;

    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     y;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op, x1, x2, in_tag, out_ready,
        input  in_ready, out_valid, y, ovf, out_tag
    );

    modport slave (
        input  in_valid, op, x1, x2, in_tag, out_ready,
        output in_ready, out_valid, y, ovf, out_tag
    );
endinterface

// File: rtl/fpu_faddsub_pipe.sv
// Three-stage parametrised IEEE-754 add/subtract (RNE, gradual underflow) with tag pass-through.
// Define FPU_FADDSUB_FTZ_EN to flush subnormal inputs and results to zero.
module fpu_faddsub_pipe #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    fpu_faddsub_pipe_if.slave  bus
);
    localparam int W   = 1 + EW + MW;
    localparam int FW  = MW + 4;                 // hidden + fraction + guard + round + sticky
    localparam int LZW = $clog2(FW + 1);
    localparam int XW  = (EW + 2 > LZW + 1) ? EW + 2 : LZW + 1;
    localparam logic [EW-1:0] EMAX = '1;
    localparam logic [W-1:0]  QBIT = {{(EW+1){1'b0}}, 1'b1, {(MW-1){1'b0}}};
    localparam logic [W-1:0]  CNAN = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic adv;
    logic out_valid_q, ovf_q;
    logic [W-1:0] y_q;
    logic [TAG_W-1:0] out_tag_q;

    assign adv           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_tag   = out_tag_q;

    // S1: unpack, classify, order by magnitude, align the smaller operand
    logic          a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, swap;
    logic [EW-1:0] a_exp, b_exp, big_exp, small_exp, big_e, small_e;
    logic [MW-1:0] a_man, b_man, big_man, small_man;
    logic          big_sign, small_sign;
    logic [XW-1:0] ediff, shamt;
    logic [2*FW-1:0] aligned;
    logic          sp1_d;
    logic [W-1:0]  spv1_d;
    logic [FW-1:0] mb1_d, ms1_d;

    always_comb begin
        a_sign = bus.x1[W-1];
        a_exp  = bus.x1[W-2:MW];
        a_man  = bus.x1[MW-1:0];
        b_sign = bus.x2[W-1] ^ bus.op;
        b_exp  = bus.x2[W-2:MW];
        b_man  = bus.x2[MW-1:0];
`ifdef FPU_FADDSUB_FTZ_EN
        if (a_exp == '0) a_man = '0;
        if (b_exp == '0) b_man = '0;
`endif
        a_nan = (a_exp == EMAX) && (a_man != '0);
        a_inf = (a_exp == EMAX) && (a_man == '0);
        b_nan = (b_exp == EMAX) && (b_man != '0);
        b_inf = (b_exp == EMAX) && (b_man == '0);
        sp1_d = a_nan | a_inf | b_nan | b_inf;
        spv1_d = '0;
        if (a_nan)
            spv1_d = bus.x1 | QBIT;
        else if (b_nan)
            spv1_d = bus.x2 | QBIT;
        else if (a_inf && b_inf)
            spv1_d = (a_sign == b_sign) ? {a_sign, EMAX, {MW{1'b0}}} : CNAN;
        else if (a_inf)
            spv1_d = {a_sign, EMAX, {MW{1'b0}}};
        else if (b_inf)
            spv1_d = {b_sign, EMAX, {MW{1'b0}}};

        swap       = {b_exp, b_man} > {a_exp, a_man};
        big_sign   = swap ? b_sign : a_sign;
        big_exp    = swap ? b_exp  : a_exp;
        big_man    = swap ? b_man  : a_man;
        small_sign = swap ? a_sign : b_sign;
        small_exp  = swap ? a_exp  : b_exp;
        small_man  = swap ? a_man  : b_man;
        big_e      = (big_exp == '0)   ? EW'(1) : big_exp;
        small_e    = (small_exp == '0) ? EW'(1) : small_exp;
        ediff      = XW'(big_e - small_e);
        shamt      = (ediff > XW'(FW)) ? XW'(FW) : ediff;
        aligned    = {(small_exp != '0), small_man, 3'b000, {FW{1'b0}}} >> shamt;
        ms1_d      = {aligned[2*FW-1:FW+1], |aligned[FW:0]};
        mb1_d      = {(big_exp != '0), big_man, 3'b000};
    end

    logic             v1_q, sp1_q, sign1_q, sub1_q, zs1_q;
    logic [TAG_W-1:0] tag1_q;
    logic [W-1:0]     spv1_q;
    logic [EW-1:0]    exp1_q;
    logic [FW-1:0]    mb1_q, ms1_q;

    // S2: magnitude add/subtract, carry renormalise, leading-zero count
    logic [FW:0]    sum;
    logic [FW-1:0]  man2_d;
    logic [XW-1:0]  exp2_d;
    logic [LZW-1:0] lz2_d;
    logic           zero2_d;

    always_comb begin
        sum = sub1_q ? ({1'b0, mb1_q} - {1'b0, ms1_q}) : ({1'b0, mb1_q} + {1'b0, ms1_q});
        if (sum[FW]) begin
            man2_d = {sum[FW:2], sum[1] | sum[0]};
            exp2_d = XW'(exp1_q) + XW'(1);
        end else begin
            man2_d = sum[FW-1:0];
            exp2_d = XW'(exp1_q);
        end
        lz2_d = LZW'(FW);
        for (int i = 0; i < FW; i++) begin
            if (man2_d[i]) lz2_d = LZW'(FW - 1 - i);
        end
        zero2_d = (man2_d == '0);
    end

    logic             v2_q, sp2_q, sign2_q, zs2_q, zero2_q;
    logic [TAG_W-1:0] tag2_q;
    logic [W-1:0]     spv2_q;
    logic [XW-1:0]    exp2_q;
    logic [FW-1:0]    man2_q;
    logic [LZW-1:0]   lz2_q;

    // S3: left-normalise without dropping below exponent 1, round to nearest even, pack
    logic [XW-1:0] emin1, sh3, en, ef;
    logic [FW-1:0] mn;
    logic          rup;
    logic [MW+1:0] rnd;
    logic [MW-1:0] frac;
    logic [W-1:0]  y_d;
    logic          ovf_d;

    always_comb begin
        emin1 = exp2_q - XW'(1);
        sh3   = (XW'(lz2_q) < emin1) ? XW'(lz2_q) : emin1;
        mn    = man2_q << sh3;
        en    = exp2_q - sh3;
        rup   = mn[2] & (mn[3] | mn[1] | mn[0]);
        rnd   = {1'b0, mn[FW-1:3]} + {{(MW+1){1'b0}}, rup};
        if (rnd[MW+1]) begin
            ef   = en + XW'(1);
            frac = rnd[MW:1];
        end else begin
            ef   = rnd[MW] ? en : '0;
            frac = rnd[MW-1:0];
        end
        ovf_d = 1'b0;
        if (sp2_q) begin
            y_d = spv2_q;
        end else if (zero2_q) begin
            y_d = {zs2_q, {(W-1){1'b0}}};
        end else if (ef >= XW'(EMAX)) begin
            y_d   = {sign2_q, EMAX, {MW{1'b0}}};
            ovf_d = v2_q;
        end else begin
            y_d = {sign2_q, ef[EW-1:0], frac};
`ifdef FPU_FADDSUB_FTZ_EN
            if (ef == '0) y_d = {sign2_q, {(W-1){1'b0}}};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; sp1_q <= 1'b0; sign1_q <= 1'b0; sub1_q <= 1'b0; zs1_q <= 1'b0;
            tag1_q <= '0; spv1_q <= '0; exp1_q <= '0; mb1_q <= '0; ms1_q <= '0;
            v2_q <= 1'b0; sp2_q <= 1'b0; sign2_q <= 1'b0; zs2_q <= 1'b0; zero2_q <= 1'b0;
            tag2_q <= '0; spv2_q <= '0; exp2_q <= '0; man2_q <= '0; lz2_q <= '0;
            out_valid_q <= 1'b0; y_q <= '0; ovf_q <= 1'b0; out_tag_q <= '0;
        end else if (adv) begin
            v1_q    <= bus.in_valid;
            tag1_q  <= bus.in_tag;
            sp1_q   <= sp1_d;
            spv1_q  <= spv1_d;
            sign1_q <= big_sign;
            sub1_q  <= big_sign ^ small_sign;
            zs1_q   <= big_sign & small_sign;
            exp1_q  <= big_e;
            mb1_q   <= mb1_d;
            ms1_q   <= ms1_d;

            v2_q    <= v1_q;
            tag2_q  <= tag1_q;
            sp2_q   <= sp1_q;
            spv2_q  <= spv1_q;
            sign2_q <= sign1_q;
            zs2_q   <= zs1_q;
            zero2_q <= zero2_d;
            exp2_q  <= exp2_d;
            man2_q  <= man2_d;
            lz2_q   <= lz2_d;

            out_valid_q <= v2_q;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            out_tag_q   <= tag2_q;
        end
    end
endmodule

// File: tb/tb_fpu_faddsub_pipe.sv
// Scoreboard bench for fpu_faddsub_pipe: single-precision and half-precision instances,
// directed vectors, backpressure, and reset with operations in flight.
module tb_fpu_faddsub_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    fpu_faddsub_pipe_if #(.EW(8), .MW(23), .TAG_W(5)) i32 ();
    fpu_faddsub_pipe_if #(.EW(5), .MW(10), .TAG_W(5)) i16 ();

    fpu_faddsub_pipe #(.EW(8), .MW(23), .TAG_W(5)) u32 (.clk(clk), .rst(rst), .bus(i32.slave));
    fpu_faddsub_pipe #(.EW(5), .MW(10), .TAG_W(5)) u16 (.clk(clk), .rst(rst), .bus(i16.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor for the single-precision instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && i32.out_valid) begin
                if (i32.out_ready) begin
                    if (q32.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected32 actual tag=%0d y=%h required=no result", i32.out_tag, i32.y);
                    end else begin
                        e = q32.pop_front();
                        $display("txn32 tag=%0d y=%h ovf=%0d", i32.out_tag, i32.y, i32.ovf);
                        chk("y32", i32.y, e.y);
                        chk("ovf32", {31'd0, i32.ovf}, {31'd0, e.ovf});
                        chk("tag32", {27'd0, i32.out_tag}, {27'd0, e.tag});
                        if (e.lat) chk("latency32", cyc - e.acc, 32'd3);
                    end
                end else begin
                    chk("stall_in_ready", {31'd0, i32.in_ready}, 32'd0);
                    if (q32.size() != 0) begin
                        chk("stall_y", i32.y, q32[0].y);
                        chk("stall_tag", {27'd0, i32.out_tag}, {27'd0, q32[0].tag});
                    end
                end
            end
        end
    end

    // Monitor for the half-precision instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && i16.out_valid && i16.out_ready) begin
                if (q16.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected16 actual tag=%0d y=%h required=no result", i16.out_tag, i16.y);
                end else begin
                    e = q16.pop_front();
                    $display("txn16 tag=%0d y=%h ovf=%0d", i16.out_tag, i16.y, i16.ovf);
                    chk("y16", {16'd0, i16.y}, e.y);
                    chk("ovf16", {31'd0, i16.ovf}, {31'd0, e.ovf});
                    chk("tag16", {27'd0, i16.out_tag}, {27'd0, e.tag});
                    if (e.lat) chk("latency16", cyc - e.acc, 32'd3);
                end
            end
        end
    end

    task automatic send32(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] ey, input logic eovf,
                          input bit lat);
        int  waited = 0;
        bit  done   = 0;
        exp_t e;
        i32.in_valid = 1'b1; i32.op = op; i32.x1 = a; i32.x2 = b; i32.in_tag = tag;
        while (!done) begin
            @(negedge clk);
            if (i32.in_ready) begin
                e.y = ey; e.ovf = eovf; e.tag = tag; e.acc = cyc; e.lat = lat;
                q32.push_back(e);
                done = 1;
            end else if (++waited > 50) begin
                total++; bad++;
                $display("FAIL accept32_timeout actual=no in_ready required=accept tag=%0d", tag);
                done = 1;
            end
            @(posedge clk); #1;
        end
        i32.in_valid = 1'b0;
    endtask

    task automatic send16(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] tag, input logic [15:0] ey, input logic eovf,
                          input bit lat);
        int  waited = 0;
        bit  done   = 0;
        exp_t e;
        i16.in_valid = 1'b1; i16.op = op; i16.x1 = a; i16.x2 = b; i16.in_tag = tag;
        while (!done) begin
            @(negedge clk);
            if (i16.in_ready) begin
                e.y = {16'd0, ey}; e.ovf = eovf; e.tag = tag; e.acc = cyc; e.lat = lat;
                q16.push_back(e);
                done = 1;
            end else if (++waited > 50) begin
                total++; bad++;
                $display("FAIL accept16_timeout actual=no in_ready required=accept tag=%0d", tag);
                done = 1;
            end
            @(posedge clk); #1;
        end
        i16.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q32.size() != 0 || q16.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q32.size(), q16.size());
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] va[10], vb[10], vy[10];
    logic        vop[10], vovf[10];
    logic [31:0] pa[6], pb[6], py[6];
    logic        pop_[6];

    initial begin
        va[0] = 32'h3F800000; vb[0] = 32'h33800000; vop[0] = 0; vy[0] = 32'h3F800000; vovf[0] = 0;
        va[1] = 32'h3F800000; vb[1] = 32'h33C00000; vop[1] = 0; vy[1] = 32'h3F800001; vovf[1] = 0;
        va[2] = 32'h3F800000; vb[2] = 32'h3F800000; vop[2] = 1; vy[2] = 32'h00000000; vovf[2] = 0;
        va[3] = 32'h80000000; vb[3] = 32'h80000000; vop[3] = 0; vy[3] = 32'h80000000; vovf[3] = 0;
        va[4] = 32'h7F7FFFFF; vb[4] = 32'h7F7FFFFF; vop[4] = 0; vy[4] = 32'h7F800000; vovf[4] = 1;
        va[5] = 32'h7F800000; vb[5] = 32'h7F800000; vop[5] = 1; vy[5] = 32'hFFC00000; vovf[5] = 0;
        va[6] = 32'h7FA00000; vb[6] = 32'h3F800000; vop[6] = 0; vy[6] = 32'h7FE00000; vovf[6] = 0;
`ifdef FPU_FADDSUB_FTZ_EN
        va[7] = 32'h00800000; vb[7] = 32'h00400000; vop[7] = 1; vy[7] = 32'h00800000; vovf[7] = 0;
`else
        va[7] = 32'h00800000; vb[7] = 32'h00400000; vop[7] = 1; vy[7] = 32'h00400000; vovf[7] = 0;
`endif
        va[8] = 32'hBF800000; vb[8] = 32'hC0000000; vop[8] = 0; vy[8] = 32'hC0400000; vovf[8] = 0;
        va[9] = 32'h3F800000; vb[9] = 32'h3F000000; vop[9] = 1; vy[9] = 32'h3F000000; vovf[9] = 0;

        pa[0] = 32'h3F800000; pb[0] = 32'h40000000; pop_[0] = 0; py[0] = 32'h40400000;
        pa[1] = 32'h3F800000; pb[1] = 32'h3F800000; pop_[1] = 0; py[1] = 32'h40000000;
        pa[2] = 32'h40000000; pb[2] = 32'h40000000; pop_[2] = 0; py[2] = 32'h40800000;
        pa[3] = 32'h40400000; pb[3] = 32'h3F800000; pop_[3] = 1; py[3] = 32'h40000000;
        pa[4] = 32'h3FC00000; pb[4] = 32'h3F000000; pop_[4] = 0; py[4] = 32'h40000000;
        pa[5] = 32'h40800000; pb[5] = 32'h3F800000; pop_[5] = 1; py[5] = 32'h40400000;

        i32.in_valid = 0; i32.op = 0; i32.x1 = '0; i32.x2 = '0; i32.in_tag = '0; i32.out_ready = 1;
        i16.in_valid = 0; i16.op = 0; i16.x1 = '0; i16.x2 = '0; i16.in_tag = '0; i16.out_ready = 1;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, i32.out_valid}, 32'd0);
        chk("rst_y", i32.y, 32'd0);
        chk("rst_ovf", {31'd0, i32.ovf}, 32'd0);
        chk("rst_tag", {27'd0, i32.out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, i32.in_ready}, 32'd1);
        @(posedge clk); #1;

        // basic add with latency check on an idle pipe
        send32(1'b0, 32'h3F800000, 32'h40000000, 5'd7, 32'h40400000, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 10; i++)
            send32(vop[i], va[i], vb[i], 5'(10 + i), vy[i], vovf[i], 1'b0);
        drain();

        // six back-to-back ops with the consumer stalled in cycles 4..6
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send32(pop_[i], pa[i], pb[i], 5'(i), py[i], 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 i32.out_ready = 0;
                repeat (3) @(posedge clk);
                #1 i32.out_ready = 1;
            end
        join
        drain();

        // reset with operations in flight; the third op coincides with reset
        i32.in_valid = 1; i32.op = 0; i32.x1 = 32'h3F800000; i32.x2 = 32'h40000000; i32.in_tag = 5'd20;
        @(posedge clk); #1 i32.in_tag = 5'd21;
        @(posedge clk); #1 i32.in_tag = 5'd22; rst = 1;
        @(posedge clk); #1 rst = 0; i32.in_valid = 0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, i32.out_valid}, 32'd0);
        chk("midrst_y", i32.y, 32'd0);
        chk("midrst_ovf", {31'd0, i32.ovf}, 32'd0);
        chk("midrst_tag", {27'd0, i32.out_tag}, 32'd0);
        chk("midrst_in_ready", {31'd0, i32.in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", {31'd0, i32.out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // half-precision instance
        send16(1'b0, 16'h3C00, 16'h4000, 5'd3, 16'h4200, 1'b0, 1'b1);
        drain();
        send16(1'b1, 16'h4000, 16'h3C00, 5'd4, 16'h3C00, 1'b0, 1'b0);
        send16(1'b0, 16'h7BFF, 16'h7BFF, 5'd5, 16'h7C00, 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_faddsub_pipe.md
Name: fpu_faddsub_pipe

Overview:
- Parametrised, handshaked successor to the fixed 3-stage single-precision subtractor in the FPU.
- Performs IEEE-754 add or subtract, selected per operation, for any exponent/mantissa width.
- Uses round-to-nearest-even with gradual underflow, and carries a pass-through tag for register-file writeback.
- Sits between the FPU issue logic and the FPU writeback mux; backpressure from writeback stalls the whole pipe.

Parameters:
- EW, 8, exponent width in bits (≥3).
- MW, 23, stored mantissa width in bits (≥2); the operand width is 1+EW+MW.
- TAG_W, 5, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  pipe can accept this cycle.
- op  in  1  0 = x1+x2, 1 = x1−x2.
- x1  in  1+EW+MW  operand 1.
- x2  in  1+EW+MW  operand 2.
- in_tag  in  TAG_W  tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- y  out  1+EW+MW  result.
- ovf  out  1  finite operands produced an infinity.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset, sampled on the clk rising edge with rst=1: all stage valid bits, out_valid, y, ovf and out_tag are cleared to 0. Operations in flight are discarded. in_ready=1 in the cycle after reset.
- Stage structure: three register stages S1 → S2 → S3. S3 drives y, ovf, out_tag and out_valid.
  - S1: unpack operands, align, swap.
  - S2: add/subtract mantissas, compute sticky bit, leading-zero count.
  - S3: normalise, round, handle specials.
- Global advance: adv = ~out_valid | out_ready. When adv=1 every stage shifts forward; when adv=0 every stage holds.
- in_ready = adv, driven combinationally; it has no other dependence on in_valid.
- Acceptance: an operation is accepted when in_valid & in_ready. A bubble enters S1 when in_valid=0 during adv.
- Latency: exactly 3 advancing edges from acceptance to out_valid=1.
- Throughput: 1 operation per cycle with out_ready held high.
- Ordering: results are delivered strictly in order, with no loss or duplication under any stall pattern.
- Output stability: y, ovf and out_tag hold stable while out_valid=1 and out_ready=0.
- Datapath, S1:
  - x2 sign is inverted when op=1.
  - A zero exponent is treated as exponent 1 with hidden bit 0; otherwise the hidden bit is 1.
  - The larger-magnitude operand is the one with the larger exponent; on equal exponents, the larger mantissa wins.
  - The exponent difference saturates at MW+4.
  - Mantissas carry a guard bit, a round bit and an OR-reduced sticky bit of all shifted-out bits.
- Datapath, S2/S3:
  - Carry-out renormalises right by 1, with the sticky bit updated.
  - The leading-zero shift is limited so the exponent does not go below 1; otherwise the result is subnormal with exponent 0.
  - Rounding is round-to-nearest-even. A rounding carry increments the exponent.
- Zero results:
  - Exact-zero sum of opposite-sign operands gives +0.
  - (−0)+(−0) gives −0.
- Overflow: exponent reaching all-ones from finite inputs gives ±Inf with ovf=1. ovf=0 in every other case.
- Special operands:
  - Any NaN operand returns a quiet NaN: the first NaN (x1 precedence) with its quiet bit set.
  - Inf ± finite gives that Inf.
  - Inf + Inf of the same sign gives that Inf.
  - Inf − Inf of effective opposite signs gives the canonical NaN: sign 1, exponent all-ones, MSB of mantissa set, remaining bits 0.
- Simultaneous events:
  - Accept and deliver in the same cycle is legal.
  - If rst is asserted in the same cycle as in_valid, reset wins and the operation is dropped.

Optional Feature:
- Macro: FPU_FADDSUB_FTZ_EN.
- When defined:
  - Subnormal inputs (exponent 0) are treated as zero of the same sign before S1.
  - Any result that would be subnormal is flushed to a zero with the result sign; an exact zero follows the zero-sign rule above.
  - ovf is unaffected.
- When undefined: full gradual underflow as described above. Port list and latency are identical in both builds.

Test Plan:
- Basic add: EW=8, MW=23, op=0, x1=0x3F800000, x2=0x40000000 → y=0x40400000, ovf=0, out_valid exactly 3 cycles after acceptance, out_tag echoed.
- Round-to-nearest-even and zero sign:
  - op=0, 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even).
  - op=0, 0x3F800000 + 0x33C00000 → 0x3F800001.
  - op=1, 0x3F800000 − 0x3F800000 → 0x00000000.
  - op=0, 0x80000000 + 0x80000000 → 0x80000000.
- Specials:
  - op=0, 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with ovf=1.
  - op=1, 0x7F800000 − 0x7F800000 → 0xFFC00000 with ovf=0.
  - op=0, 0x7FA00000 + 0x3F800000 → 0x7FE00000.
- Subnormal: op=1, 0x00800000 − 0x00400000 → 0x00400000. With FPU_FADDSUB_FTZ_EN the result is 0x00800000 (input subnormal flushed).
- Backpressure:
  - Issue 6 back-to-back ops with tags 0..5; hold out_ready=0 for cycles 4–6.
  - Required: in_ready=0 while stalled, y/out_tag stable while stalled.
  - Tags emerge 0..5 in order, each exactly once, with correct sums.
- Reset mid-flight and parameter sweep:
  - Assert rst for 1 cycle with 3 ops in flight → out_valid=0, y=0, ovf=0, out_tag=0 next cycle; no stale result appears afterwards.
  - Repeat the basic add at EW=5, MW=10: 0x3C00 + 0x4000 → 0x4200.
